// File: rtl/neat_pkg.sv
// Shared defaults and slot-indexing helper for the mutation lane datapath.
package neat_pkg;

  localparam int unsigned GENE_SZ_DEF = 64;
  localparam int unsigned SLOTS_DEF   = 6;

  // Slot 0 sits at the MSB end of a left-justified gene bus.
  function automatic int unsigned slot_lsb(input int unsigned slots,
                                           input int unsigned gene_sz,
                                           input int unsigned idx);
    return (slots - idx - 1) * gene_sz;
  endfunction

endpackage

// File: rtl/gene_fifo_mw1r.sv
// Register FIFO with PORTS parallel write lanes (lanes 0..wr_n-1 used) and one read port.
module gene_fifo_mw1r #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned PORTS = 6,
  parameter int unsigned DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [$clog2(PORTS+1)-1:0]       wr_n,
  input  logic [PORTS-1:0][WIDTH-1:0]      wr_data,
  input  logic                             rd_en,
  output logic [WIDTH-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]       level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Storage is deliberately left unreset; occupancy gates every visible read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (wr_en && (i < 32'(wr_n))) begin
        mem_q[wr_ptr_q + PW'(i)] <= wr_data[i];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(wr_n);
      level_d  = level_d + LW'(wr_n);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      level_d  = level_d - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/gene_out_collector.sv
// Buffers six-slot gene beats and streams them one gene per cycle with genome tagging.
module gene_out_collector
  import neat_pkg::*;
#(
  parameter int unsigned GENE_SZ = GENE_SZ_DEF,
  parameter int unsigned SLOTS   = SLOTS_DEF,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SLOTS*GENE_SZ-1:0]      in_bus,
  input  logic [$clog2(SLOTS+1)-1:0]    in_count,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [GENE_SZ-1:0]            out_gene,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic [CNT_W-1:0]              genome_genes,
  output logic                          genome_done
);

  localparam int unsigned CW = $clog2(SLOTS+1);
  localparam int unsigned LW = $clog2(DEPTH+1);
  localparam int unsigned EW = GENE_SZ + 1;

  logic [CW-1:0]             n;
  logic [SLOTS-1:0][EW-1:0]  wr_data;
  logic [EW-1:0]             rd_data;
  logic                      push, pop;
  logic [CNT_W-1:0]          genes_q, genes_d;
  logic                      done_q, done_d;

  // A count of zero with last set becomes a single all-zero terminator entry.
  always_comb begin
    n = (in_count > CW'(SLOTS)) ? CW'(SLOTS) : in_count;
    if ((in_count == '0) && in_last) begin
      n = CW'(1);
    end
    for (int unsigned i = 0; i < SLOTS; i++) begin
      wr_data[i] = {in_last && ((i + 1) == 32'(n)),
                    in_bus[slot_lsb(SLOTS, GENE_SZ, i) +: GENE_SZ]};
    end
    if (in_count == '0) begin
      wr_data[0][GENE_SZ-1:0] = '0;
    end
  end

  assign in_ready = (LW'(DEPTH) - level) >= LW'(SLOTS);
  assign push     = in_valid && in_ready && (n != '0);
  assign out_valid = (level != '0);
  assign pop      = out_valid && out_ready;
  assign out_gene = out_valid ? rd_data[GENE_SZ-1:0] : '0;
  assign out_last = out_valid && rd_data[GENE_SZ];

  gene_fifo_mw1r #(
    .WIDTH (EW),
    .PORTS (SLOTS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_n    (n),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .level   (level)
  );

  always_comb begin
    genes_d = genes_q;
    done_d  = 1'b0;
    if (pop) begin
      if (out_last) begin
        genes_d = '0;
        done_d  = 1'b1;
      end else begin
        genes_d = genes_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      genes_q <= '0;
      done_q  <= 1'b0;
    end else begin
      genes_q <= genes_d;
      done_q  <= done_d;
    end
  end

  assign genome_genes = genes_q;
  assign genome_done  = done_q;

endmodule

// File: tb/tb_gene_out_collector.sv
// Bench for gene_out_collector: vector table, directed corner sequences, random stimulus vs queue model.
module tb_gene_out_collector;

  localparam int GS = 64;
  localparam int SL = 6;
  localparam int DP = 16;
  localparam int CN = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [SL*GS-1:0] in_bus;
  logic [2:0]       in_count;
  logic             in_last, in_valid, in_ready;
  logic [GS-1:0]    out_gene;
  logic             out_last, out_valid, out_ready;
  logic [4:0]       level;
  logic [CN-1:0]    genome_genes;
  logic             genome_done;

  always #5 clk = ~clk;

  gene_out_collector #(
    .GENE_SZ (GS),
    .SLOTS   (SL),
    .DEPTH   (DP),
    .CNT_W   (CN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_bus       (in_bus),
    .in_count     (in_count),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_gene     (out_gene),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .genome_genes (genome_genes),
    .genome_done  (genome_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        last;
    logic [63:0] gene;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_gg;
  logic        m_done;
  logic [63:0] gv [SL];

  typedef struct {
    bit          v;
    int unsigned cnt;
    bit          lst;
    bit          rdy;
    logic [63:0] g0, g1, g2;
    int unsigned e_level;
    bit          e_valid;
    logic [63:0] e_gene;
    bit          e_last;
    int unsigned e_gg;
    bit          e_done;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".level"},     64'(level),        64'(sz));
    chk({tag, ".out_valid"}, 64'(out_valid),    64'(sz != 0));
    chk({tag, ".out_gene"},  out_gene,          (sz != 0) ? mq[0].gene : 64'd0);
    chk({tag, ".out_last"},  64'(out_last),     (sz != 0) ? 64'(mq[0].last) : 64'd0);
    chk({tag, ".in_ready"},  64'(in_ready),     64'((DP - sz) >= SL));
    chk({tag, ".genes"},     64'(genome_genes), 64'(m_gg));
    chk({tag, ".done"},      64'(genome_done),  64'(m_done));
  endtask

  // Drives one cycle, advances the model by the stated rules, then compares.
  task automatic step(input string tag, input bit v, input int unsigned cnt,
                      input bit lst, input bit rdy, output bit acc);
    int unsigned n;
    bit          pop;
    ent_t        e;
    in_valid  = v;
    in_count  = 3'(cnt);
    in_last   = lst;
    out_ready = rdy;
    for (int i = 0; i < SL; i++) in_bus[(SL-i)*GS-1 -: GS] = gv[i];
    acc    = v && ((DP - mq.size()) >= SL);
    pop    = rdy && (mq.size() != 0);
    m_done = 1'b0;
    if (pop) begin
      e = mq.pop_front();
      if (e.last) begin
        m_gg   = '0;
        m_done = 1'b1;
      end else begin
        m_gg++;
      end
    end
    if (acc) begin
      n = (cnt > SL) ? SL : cnt;
      if (cnt == 0 && lst) mq.push_back('{1'b1, 64'd0});
      else for (int unsigned i = 0; i < n; i++) mq.push_back('{lst && (i == n - 1), gv[i]});
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic set_genes(input logic [63:0] base);
    for (int i = 0; i < SL; i++) gv[i] = base + 64'(i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int beats, maxlvl, budget;

    tbl[0]  = '{1, 3, 0, 1, 64'hA, 64'hB, 64'hC, 3, 1, 64'hA, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 64'h0, 64'h0, 64'h0, 2, 1, 64'hB, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 1, 64'h0, 64'h0, 64'h0, 1, 1, 64'hC, 0, 2, 0};
    tbl[3]  = '{0, 0, 0, 1, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, 3, 0};
    tbl[4]  = '{1, 2, 1, 1, 64'h1, 64'h2, 64'h0, 2, 1, 64'h1, 0, 3, 0};
    tbl[5]  = '{0, 0, 0, 1, 64'h0, 64'h0, 64'h0, 1, 1, 64'h2, 1, 4, 0};
    tbl[6]  = '{0, 0, 0, 1, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 1, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 1, 64'h5, 64'h6, 64'h7, 1, 1, 64'h0, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, 0, 1};
    tbl[10] = '{1, 0, 0, 1, 64'h8, 64'h9, 64'hA, 0, 0, 64'h0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, 0, 0};

    rst = 1'b1; in_valid = 1'b0; in_count = '0; in_last = 1'b0; out_ready = 1'b0; in_bus = '0;
    m_gg = '0; m_done = 1'b0;
    set_genes(64'h0);
    #12;
    chk("rst.level",     64'(level),        64'd0);
    chk("rst.out_valid", 64'(out_valid),    64'd0);
    chk("rst.out_gene",  out_gene,          64'd0);
    chk("rst.out_last",  64'(out_last),     64'd0);
    chk("rst.in_ready",  64'(in_ready),     64'd1);
    chk("rst.genes",     64'(genome_genes), 64'd0);
    chk("rst.done",      64'(genome_done),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      gv[0] = tbl[k].g0; gv[1] = tbl[k].g1; gv[2] = tbl[k].g2;
      gv[3] = 64'hFFFF_0000_0000_0003; gv[4] = 64'hFFFF_0000_0000_0004; gv[5] = 64'hFFFF_0000_0000_0005;
      step("tbl", tbl[k].v, tbl[k].cnt, tbl[k].lst, tbl[k].rdy, acc);
      chk($sformatf("tbl%0d.level", k), 64'(level),        64'(tbl[k].e_level));
      chk($sformatf("tbl%0d.valid", k), 64'(out_valid),    64'(tbl[k].e_valid));
      chk($sformatf("tbl%0d.gene", k),  out_gene,          tbl[k].e_gene);
      chk($sformatf("tbl%0d.last", k),  64'(out_last),     64'(tbl[k].e_last));
      chk($sformatf("tbl%0d.gg", k),    64'(genome_genes), 64'(tbl[k].e_gg));
      chk($sformatf("tbl%0d.done", k),  64'(genome_done),  64'(tbl[k].e_done));
    end

    // Backpressure: 12 buffered blocks the third beat until two pops.
    set_genes(64'h100); step("bp", 1, 6, 0, 0, acc);
    set_genes(64'h200); step("bp", 1, 6, 0, 0, acc);
    chk("bp.level12", 64'(level), 64'd12);
    chk("bp.ready0",  64'(in_ready), 64'd0);
    set_genes(64'h300); step("bp", 1, 6, 0, 0, acc);
    chk("bp.held", 64'(level), 64'd12);
    step("bp", 1, 6, 0, 1, acc);
    step("bp", 1, 6, 0, 1, acc);
    chk("bp.level10", 64'(level), 64'd10);
    chk("bp.ready1",  64'(in_ready), 64'd1);
    step("bp", 1, 6, 0, 0, acc);
    chk("bp.level16", 64'(level), 64'd16);
    for (int k = 0; k < 16; k++) step("bp.drain", 0, 0, 0, 1, acc);
    chk("bp.empty", 64'(level), 64'd0);

    // Wrap: 40 genes in beats of 5, ordering checked by the model every cycle.
    beats = 0; maxlvl = 0; budget = 0;
    while (beats < 8 && budget < 200) begin
      set_genes(64'h1000 + 64'(beats * 5));
      step("wrap", 1, 5, 0, 1, acc);
      if (acc) beats++;
      if (int'(level) > maxlvl) maxlvl = int'(level);
      budget++;
    end
    chk("wrap.beats", 64'(beats), 64'd8);
    budget = 0;
    while (mq.size() != 0 && budget < 50) begin
      step("wrap.drain", 0, 0, 0, 1, acc);
      budget++;
    end
    chk("wrap.maxlvl_le16", 64'(maxlvl <= 16), 64'd1);
    chk("wrap.empty", 64'(level), 64'd0);

    // Push and pop together, then asynchronous reset mid-stream.
    set_genes(64'h2000); step("pp", 1, 4, 0, 0, acc);
    chk("pp.level4", 64'(level), 64'd4);
    set_genes(64'h2100); step("pp", 1, 6, 0, 1, acc);
    chk("pp.level9", 64'(level), 64'd9);
    step("pp", 0, 0, 0, 1, acc);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.out_valid", 64'(out_valid),    64'd0);
    chk("arst.level",     64'(level),        64'd0);
    chk("arst.in_ready",  64'(in_ready),     64'd1);
    chk("arst.genes",     64'(genome_genes), 64'd0);
    mq.delete(); m_gg = '0; m_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < SL; i++) gv[i] = {$urandom, $urandom};
      step("rnd", ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7), acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
